// File: rtl/mips_load_store_unit.sv
// Load/store unit bridging a MIPS datapath request port onto an Avalon-MM master.
// One request at a time: IDLE accepts, BUS runs the Avalon transfer, RESP pulses completion.
module mips_load_store_unit #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_r;
    logic        write_r;
    logic        signed_r;
    logic [1:0]  size_r;
    logic [1:0]  lane_r;

    logic [1:0]  lane_s;
    logic        illegal_s;

    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] replicate_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] wd;
        case (size)
            2'b00:   wd = {4{wdata[7:0]}};
            2'b01:   wd = {2{wdata[15:0]}};
            2'b10:   wd = wdata;
            default: wd = 32'h0000_0000;
        endcase
        return wd;
    endfunction

    // Lane offset is already forced to the access size, so word loads see a zero shift.
    function automatic logic [31:0] format_load(input logic [1:0] size, input logic [1:0] lane,
                                                input logic sgn, input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] res;
        sh = rdata >> {lane, 3'b000};
        case (size)
            2'b00:   res = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   res = {{16{sgn & sh[15]}}, sh[15:0]};
            2'b10:   res = sh;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Classify the incoming request and derive its effective byte lane.
    always_comb begin
        lane_s    = 2'b00;
        illegal_s = 1'b0;
        case (req_size)
            2'b00: begin
                lane_s    = req_addr[1:0];
                illegal_s = 1'b0;
            end
            2'b01: begin
                lane_s    = {req_addr[1], 1'b0};
                illegal_s = (ALIGN_CHECK == 1'b1) && req_addr[0];
            end
            2'b10: begin
                lane_s    = 2'b00;
                illegal_s = (ALIGN_CHECK == 1'b1) && (req_addr[1:0] != 2'b00);
            end
            default: begin
                lane_s    = 2'b00;
                illegal_s = 1'b1;
            end
        endcase
    end

    // Request/bus/response sequencer with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            req_ready  <= 1'b1;
            read       <= 1'b0;
            write      <= 1'b0;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= 32'h0000_0000;
            address    <= 32'h0000_0000;
            writedata  <= 32'h0000_0000;
            byteenable <= 4'b0000;
            write_r    <= 1'b0;
            signed_r   <= 1'b0;
            size_r     <= 2'b00;
            lane_r     <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        write_r   <= req_write;
                        signed_r  <= req_signed;
                        size_r    <= req_size;
                        lane_r    <= lane_s;
                        req_ready <= 1'b0;
                        if (illegal_s) begin
                            state_r    <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= 32'h0000_0000;
                        end else begin
                            state_r    <= BUS;
                            read       <= ~req_write;
                            write      <= req_write;
                            address    <= {req_addr[31:2], 2'b00};
                            byteenable <= lane_enable(req_size, lane_s);
                            writedata  <= replicate_wdata(req_size, req_wdata);
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUS: begin
                    if (!waitrequest) begin
                        state_r    <= RESP;
                        read       <= 1'b0;
                        write      <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= write_r ? 32'h0000_0000
                                              : format_load(size_r, lane_r, signed_r, readdata);
                    end else begin
                        state_r <= BUS;
                    end
                end
                RESP: begin
                    state_r    <= IDLE;
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state_r    <= IDLE;
                    read       <= 1'b0;
                    write      <= 1'b0;
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Directed and randomized bench for mips_load_store_unit with an arithmetic reference model
// of lane enables, store replication and load extraction.
module tb_mips_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest = 1'b0;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata = 32'h0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata = 32'h0;

    mips_load_store_unit #(.ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .address(address), .read(read), .write(write),
        .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: sizes in bytes, offsets as integers.
    function automatic int nbytes(input logic [1:0] sz);
        return 1 << int'(sz);
    endfunction

    function automatic bit m_illegal(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1'b1;
        return (int'(a[1:0]) % nbytes(sz)) != 0;
    endfunction

    function automatic int m_off(input logic [1:0] sz, input logic [31:0] a);
        return (int'(a[1:0]) / nbytes(sz)) * nbytes(sz);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int v;
        v = ((1 << nbytes(sz)) - 1) << m_off(sz, a);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] w);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % nbytes(sz)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                           input logic sg, input logic [31:0] rd);
        longint unsigned m, v;
        m = (64'd1 << (8 * nbytes(sz))) - 64'd1;
        v = ({32'd0, rd} >> (8 * m_off(sz, a))) & m;
        if (sg && (v >= (m + 64'd1) / 64'd2)) v = v + (64'hFFFF_FFFF & ~m);
        return v[31:0];
    endfunction

    // Runs one request starting at posedge+1 with the unit idle.
    task automatic do_req(input string tag, input logic wr, input logic [31:0] a,
                          input logic [1:0] sz, input logic sg, input logic [31:0] wd,
                          input int nwait, input logic [31:0] rd);
        check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_addr = a;
        req_size = sz; req_signed = sg; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (m_illegal(sz, a)) begin
            check({tag, ".err_valid"}, {31'd0, resp_valid}, 32'd1);
            check({tag, ".err_flag"}, {31'd0, resp_error}, 32'd1);
            check({tag, ".err_rdata"}, resp_rdata, 32'd0);
            check({tag, ".err_nobus"}, {30'd0, read, write}, 32'd0);
            last_rdata = 32'd0;
        end else begin
            for (int k = 0; k <= nwait; k++) begin
                waitrequest = (k < nwait);
                readdata    = (k < nwait) ? $urandom : rd;
                check({tag, ".strobe"}, {30'd0, read, write}, {30'd0, !wr, wr});
                check({tag, ".address"}, address, {a[31:2], 2'b00});
                check({tag, ".be"}, {28'd0, byteenable}, {28'd0, m_be(sz, a)});
                if (wr) check({tag, ".wdata"}, writedata, m_wd(sz, wd));
                check({tag, ".busy"}, {30'd0, resp_valid, req_ready}, 32'd0);
                req_valid = 1'($urandom_range(0, 1));
                req_addr  = $urandom;
                req_size  = 2'($urandom_range(0, 3));
                @(posedge clk); #1;
            end
            waitrequest = 1'b0;
            req_valid   = 1'b0;
            last_rdata  = wr ? 32'd0 : m_load(sz, a, sg, rd);
            check({tag, ".resp"}, {30'd0, resp_valid, resp_error}, 32'd2);
            check({tag, ".idle_bus"}, {30'd0, read, write}, 32'd0);
            check({tag, ".rdata"}, resp_rdata, last_rdata);
        end
        @(posedge clk); #1;
        check({tag, ".pulse_end"}, {29'd0, resp_valid, resp_error, req_ready}, 32'd1);
        check({tag, ".held"}, resp_rdata, last_rdata);
    endtask

    initial begin
        #2;
        check("rst.outputs", {26'd0, read, write, resp_valid, resp_error, byteenable[1:0]}, 32'd0);
        check("rst.rdata", resp_rdata | address | writedata, 32'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("rst.ready", {31'd0, req_ready}, 32'd1);

        do_req("ldw",   1'b0, 32'h100, 2'b10, 1'b1, 32'h0, 0, 32'h8000_00F0);
        do_req("ldb_s", 1'b0, 32'h103, 2'b00, 1'b1, 32'h0, 0, 32'h8512_3456);
        do_req("ldb_u", 1'b0, 32'h103, 2'b00, 1'b0, 32'h0, 0, 32'h8512_3456);
        do_req("sth",   1'b1, 32'h202, 2'b01, 1'b0, 32'h1234_ABCD, 3, 32'h0);
        do_req("misw",  1'b0, 32'h101, 2'b10, 1'b0, 32'h0, 0, 32'h0);
        do_req("sz3",   1'b0, 32'h100, 2'b11, 1'b0, 32'h0, 0, 32'h0);
        do_req("stb",   1'b1, 32'h301, 2'b00, 1'b0, 32'h77, 0, 32'h0);
        do_req("ldh_s", 1'b0, 32'h402, 2'b01, 1'b1, 32'h0, 1, 32'hC3A5_1234);

        // Reset mid-transfer while the slave is stalling.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h500; req_size = 2'b10;
        @(posedge clk); #1;
        req_valid = 1'b0; waitrequest = 1'b1;
        check("rstbus.read", {31'd0, read}, 32'd1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("rstbus.strobes", {29'd0, read, write, resp_valid}, 32'd0);
        check("rstbus.regs", address | writedata | {28'd0, byteenable}, 32'd0);
        @(posedge clk); #1;
        check("rstbus.no_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge clk); reset = 1'b0; waitrequest = 1'b0;
        @(posedge clk); #1;
        last_rdata = 32'd0;
        do_req("post_rst", 1'b0, 32'h504, 2'b10, 1'b0, 32'h0, 0, 32'hDEAD_BEEF);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] sz;
            sz = 2'($urandom_range(0, 3));
            do_req("rand", 1'($urandom_range(0, 1)), $urandom, sz, 1'($urandom_range(0, 1)),
                   $urandom, $urandom_range(0, 3), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
